// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// The FSM state encoding, frame geometry and default filter/timeout values live here.
package ps2_pkg;

    localparam int PS2_FRAME_BITS      = 11;
    localparam int PS2_DATA_BITS       = 8;
    localparam int PS2_FILTER_LEN_DEF  = 8;
    localparam int PS2_TIMEOUT_DEF     = 50000;
    localparam int PS2_TMO_W           = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    // Odd parity: data bits plus the parity bit must hold an odd number of ones.
    function automatic logic parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes both PS/2 pins, debounces the device clock and flags its falling edges.
// fall is a registered one-cycle flag; data is the synchronized data pin in that cycle.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data
);

    localparam int CNT_W = $clog2(FILTER_LEN);

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             fclk;
    logic [CNT_W-1:0] run_cnt;

    assign data = data_sync[1];

    // run_cnt counts consecutive synchronized samples that disagree with fclk;
    // fclk flips only once FILTER_LEN of them have been seen in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            fclk      <= 1'b1;
            run_cnt   <= '0;
            fall      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its neighbour.
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            fall      <= 1'b0;
            if (clk_sync[1] == fclk) begin
                run_cnt <= '0;
            end else if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
                fclk    <= clk_sync[1];
                run_cnt <= '0;
                fall    <= fclk;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver: framing, odd-parity check and inter-bit timeout.
// Good scan codes are held on code_out with a one-cycle code_valid strobe.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic [PS2_DATA_BITS-1:0] code_out,
    output logic                     code_valid,
    output logic                     parity_err,
    output logic                     frame_err
);

    logic                     fall;
    logic                     data;
    ps2_state_e               state;
    logic [2:0]               bit_cnt;
    logic [PS2_DATA_BITS-1:0] shift_reg;
    logic                     par_bit;
    logic [PS2_TMO_W-1:0]     tmo_cnt;
    logic                     tmo_hit;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data     (data)
    );

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle after a fall.
    assign tmo_hit = (tmo_cnt == PS2_TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            code_out   <= '0;
            code_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == ST_IDLE || fall) tmo_cnt <= '0;
            else                          tmo_cnt <= tmo_cnt + 1'b1;

            if (state != ST_IDLE && !fall && tmo_hit) begin
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                shift_reg <= '0;
                frame_err <= 1'b1;
            end else if (fall) begin
                unique case (state)
                    ST_IDLE: begin
                        if (!data) begin
                            state     <= ST_DATA;
                            bit_cnt   <= '0;
                            shift_reg <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg[bit_cnt] <= data;
                        if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state <= ST_PARITY;
                        else                                  bit_cnt <= bit_cnt + 1'b1;
                    end
                    ST_PARITY: begin
                        par_bit <= data;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        // A bad stop bit outranks a parity failure.
                        if (!data)                          frame_err  <= 1'b1;
                        else if (parity_ok(shift_reg, par_bit)) begin
                            code_out   <= shift_reg;
                            code_valid <= 1'b1;
                        end else                            parity_err <= 1'b1;
                        state     <= ST_IDLE;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: a scoreboard queue holds the strobe,
// held code and arrival cycle expected for each frame; a negedge monitor pops and compares.
module tb_ps2_receiver;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    typedef enum logic [1:0] {EV_NONE, EV_VALID, EV_PARITY, EV_FRAME} ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] code;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code_out;
    logic       code_valid;
    logic       parity_err;
    logic       frame_err;

    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_good = 8'h00;
    exp_t       sb[$];

    ps2_receiver #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code_out   (code_out),
        .code_valid (code_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input ev_e k, input int c);
        exp_t e;
        e.kind = k;
        e.code = last_good;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Drives the first n bits of a frame; returns the cycle of the last raw falling edge.
    task automatic send_bits(input logic [10:0] bits, input int n, output int last_edge);
        last_edge = 0;
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk   = 1'b0;
            last_edge = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop);
        logic [10:0] bits;
        logic        par;
        int          edge_cyc;
        par  = ~(^d) ^ flip_par;
        bits = {stop, par, d, 1'b0};
        send_bits(bits, PS2_FRAME_BITS - 1, edge_cyc);
        ps2_data = stop;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b0;
        edge_cyc = cyc;
        if (!stop)         push(EV_FRAME, edge_cyc + FL + 3);
        else if (flip_par) push(EV_PARITY, edge_cyc + FL + 3);
        else begin
            last_good = d;
            push(EV_VALID, edge_cyc + FL + 3);
        end
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        ev_e  got;
        exp_t e;
        if (code_valid || parity_err || frame_err) begin
            check("one_hot", 32'(code_valid) + 32'(parity_err) + 32'(frame_err), 32'd1);
            got = code_valid ? EV_VALID : (parity_err ? EV_PARITY : EV_FRAME);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'(got), 32'(EV_NONE));
            end else begin
                e = sb.pop_front();
                check("strobe_kind", 32'(got), 32'(e.kind));
                check("code_out", 32'(code_out), 32'(e.code));
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int          last_edge;
        logic [10:0] bits;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_code", 32'(code_out), 32'h00);
        check("reset_strobes", {29'd0, code_valid, parity_err, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'h1C, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        send_frame(8'h1C, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        check("hold_after_parity_err", 32'(code_out), 32'(last_good));

        send_frame(8'h29, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("hold_after_frame_err", 32'(code_out), 32'(last_good));
        send_frame(8'hF0, 1'b0, 1'b1);
        repeat (40) @(negedge clk);

        // Start plus four data bits of 0x5A, then the lines sit idle.
        bits = {1'b1, 1'b1, 8'h5A, 1'b0};
        send_bits(bits, 5, last_edge);
        ps2_data = 1'b1;
        push(EV_FRAME, last_edge + FL + 3 + TMO);
        repeat (TMO + 10) @(negedge clk);
        check("hold_after_timeout", 32'(code_out), 32'(last_good));
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (40) @(negedge clk);

        // Short clock glitches with data low: any leak would open a frame that later times out.
        ps2_data = 1'b0;
        for (int g = 0; g < 20; g++) begin
            ps2_clk = 1'b0;
            repeat (FL - 1) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (TMO + 40) @(negedge clk);
        check("hold_after_glitches", 32'(code_out), 32'(last_good));

        // Reset in the middle of a frame.
        bits = {1'b1, 1'b0, 8'h33, 1'b0};
        send_bits(bits, 6, last_edge);
        rst_n     = 1'b0;
        last_good = 8'h00;
        repeat (2) @(negedge clk);
        check("midframe_reset_code", 32'(code_out), 32'(last_good));
        check("midframe_reset_strobes", {29'd0, code_valid, parity_err, frame_err}, 32'd0);
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_code", 32'(code_out), 32'(last_good));
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        check("final_code", 32'(code_out), 32'(last_good));
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
